// File: rtl/exu_oitf_pkg.sv
// Shared sizing constants for the outstanding instruction track FIFO.
// The pointer width is derived from the depth so the two cannot disagree.
package exu_oitf_pkg;

  localparam int OITF_DEPTH  = 4;
  localparam int ITAG_WIDTH  = $clog2(OITF_DEPTH);
  localparam int RFIDX_WIDTH = 5;

endpackage

// File: rtl/exu_oitf_ptr.sv
// Wrapping pointer with a lap flag, used for both alloc and retire sides.
// The flag lets equal pointers be told apart as empty versus full.
module exu_oitf_ptr
  import exu_oitf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_i,
  output logic [ITAG_WIDTH-1:0] ptr_o,
  output logic                  flg_o
);

  logic [ITAG_WIDTH-1:0] ptr_q, ptr_d;
  logic                  flg_q, flg_d;

  always_comb begin
    ptr_d = ptr_q;
    flg_d = flg_q;
    if (inc_i) begin
      ptr_d = ptr_q + ITAG_WIDTH'(1);
      if (ptr_q == ITAG_WIDTH'(OITF_DEPTH - 1))
        flg_d = ~flg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      flg_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      flg_q <= flg_d;
    end
  end

  assign ptr_o = ptr_q;
  assign flg_o = flg_q;

endmodule

// File: rtl/exu_oitf.sv
// Outstanding instruction track FIFO for the long pipe: in-order
// alloc/retire of rd tags plus RAW/WAW hazard lookup for dispatch.
module exu_oitf
  import exu_oitf_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dis_ena,
  output logic                   dis_ready,
  output logic [ITAG_WIDTH-1:0]  dis_ptr,
  input  logic                   dis_rdwen,
  input  logic [RFIDX_WIDTH-1:0] dis_rdidx,
  input  logic                   disp_i_rs1en,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic                   disp_i_rs2en,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic                   disp_i_rdwen,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
  output logic                   oitfrd_match_disprs1,
  output logic                   oitfrd_match_disprs2,
  output logic                   oitfrd_match_disprd,
  input  logic                   oitf_ret_ena,
  output logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
  output logic                   oitf_ret_rdwen,
  output logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
  output logic                   oitf_empty,
  output logic                   oitf_full
);

  logic [ITAG_WIDTH-1:0]  alc_ptr, ret_ptr;
  logic                   alc_flg, ret_flg;
  logic                   alc_ena, ret_ena;
  logic [OITF_DEPTH-1:0]  vld_q, vld_d;
  logic [OITF_DEPTH-1:0]  rdwen_q;
  logic [RFIDX_WIDTH-1:0] rdidx_q [OITF_DEPTH];
  logic                   m_rs1, m_rs2, m_rd;

  exu_oitf_ptr u_alc (
    .clk   (clk),
    .rst   (rst),
    .inc_i (alc_ena),
    .ptr_o (alc_ptr),
    .flg_o (alc_flg)
  );

  exu_oitf_ptr u_ret (
    .clk   (clk),
    .rst   (rst),
    .inc_i (ret_ena),
    .ptr_o (ret_ptr),
    .flg_o (ret_flg)
  );

  assign oitf_empty = (alc_ptr == ret_ptr) & (alc_flg == ret_flg);
  assign oitf_full  = (alc_ptr == ret_ptr) & (alc_flg != ret_flg);
  assign alc_ena    = dis_ena & ~oitf_full;
  assign ret_ena    = oitf_ret_ena & ~oitf_empty;

  // Alloc and retire never hit the same slot: that needs full or empty,
  // and each of those blocks one side.
  always_comb begin
    vld_d = vld_q;
    if (ret_ena) vld_d[ret_ptr] = 1'b0;
    if (alc_ena) vld_d[alc_ptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      rdwen_q <= '0;
      for (int i = 0; i < OITF_DEPTH; i++)
        rdidx_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      if (alc_ena) begin
        rdwen_q[alc_ptr] <= dis_rdwen;
        rdidx_q[alc_ptr] <= dis_rdidx;
      end
    end
  end

  always_comb begin
    m_rs1 = 1'b0;
    m_rs2 = 1'b0;
    m_rd  = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (vld_q[i] & rdwen_q[i]) begin
        if (rdidx_q[i] == disp_i_rs1idx) m_rs1 = 1'b1;
        if (rdidx_q[i] == disp_i_rs2idx) m_rs2 = 1'b1;
        if (rdidx_q[i] == disp_i_rdidx)  m_rd  = 1'b1;
      end
    end
  end

  assign oitfrd_match_disprs1 = m_rs1 & disp_i_rs1en;
  assign oitfrd_match_disprs2 = m_rs2 & disp_i_rs2en;
  assign oitfrd_match_disprd  = m_rd  & disp_i_rdwen;

  assign dis_ready      = ~oitf_full;
  assign dis_ptr        = alc_ptr;
  assign oitf_ret_ptr   = ret_ptr;
  assign oitf_ret_rdwen = rdwen_q[ret_ptr];
  assign oitf_ret_rdidx = rdidx_q[ret_ptr];

endmodule
